// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, ALU select codes,
// FSM states and instruction field positions.
package alu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 24;
    localparam int DEST_HI = 18;
    localparam int DEST_LO = 16;
    localparam int SRC1_HI = 10;
    localparam int SRC1_LO = 8;
    localparam int SRC2_HI = 2;
    localparam int SRC2_LO = 0;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    // add and sub share the adder and are the only ops that update ZERO_FLAG
    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8x8 register file: one synchronous write port, two combinational read
// ports and a combinational debug read port.
module reg_file (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       we,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_addr1,
    input  logic [2:0] rd_addr2,
    input  logic [2:0] dbg_addr,
    output logic [7:0] rd_data1,
    output logic [7:0] rd_data2,
    output logic [7:0] dbg_data
);

    logic [7:0][7:0] regs;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            regs <= '0;
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU: IDLE->DECODE->EXEC->WB.
// Define ALU_ISSUE_SUB_EN to enable opcode 0x03 (sub); otherwise it is illegal.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FWD_WAIT = 1,
    parameter int ADD_WAIT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [7:0]  DATA1,
    output logic [7:0]  DATA2,
    output logic [2:0]  SELECT,
    input  logic [7:0]  RESULT,
    input  logic        ZERO,
    output logic        DONE,
    output logic        ILLEGAL,
    output logic        ZERO_FLAG,
    input  logic [2:0]  DBG_ADDR,
    output logic [7:0]  DBG_DATA
);

    localparam logic [3:0] FWD_CNT = 4'(FWD_WAIT - 1);
    localparam logic [3:0] ADD_CNT = 4'(ADD_WAIT - 1);

    state_t     state, state_nxt;
    logic [7:0] op_q, imm_q;
    logic [2:0] dest_q, src1_q;
    logic [3:0] cnt;
    logic [7:0] rd1, rd2;
    logic       legal;
    logic [7:0] d1_nxt, d2_nxt;
    logic [2:0] sel_nxt;
    logic [3:0] cnt_nxt;
    logic       unused_instr;

    // Only the decoded fields are captured; the remaining bits are don't-care.
    assign unused_instr = ^{INSTR[23:19], INSTR[15:11]};

    reg_file u_rf (
        .CLK      (CLK),
        .RESET    (RESET),
        .we       (state == WB),
        .wr_addr  (dest_q),
        .wr_data  (RESULT),
        .rd_addr1 (src1_q),
        .rd_addr2 (imm_q[SRC2_HI:SRC2_LO]),
        .dbg_addr (DBG_ADDR),
        .rd_data1 (rd1),
        .rd_data2 (rd2),
        .dbg_data (DBG_DATA)
    );

    always_comb begin
        legal   = 1'b1;
        d1_nxt  = rd1;
        d2_nxt  = rd2;
        sel_nxt = ALU_FWD;
        cnt_nxt = FWD_CNT;
        case (op_q)
            OP_LOADI: d2_nxt = imm_q;
            OP_MOV:   ;
            OP_ADD: begin
                sel_nxt = ALU_ADD;
                cnt_nxt = ADD_CNT;
            end
`ifdef ALU_ISSUE_SUB_EN
            // sub runs on the adder with a two's-complemented second operand
            OP_SUB: begin
                d2_nxt  = ~rd2 + 8'd1;
                sel_nxt = ALU_ADD;
                cnt_nxt = ADD_CNT;
            end
`endif
            OP_AND:   sel_nxt = ALU_AND;
            OP_OR:    sel_nxt = ALU_OR;
            default:  legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (INSTR_VALID) state_nxt = DECODE;
            DECODE:  state_nxt = legal ? EXEC : IDLE;
            EXEC:    if (cnt == 4'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            op_q      <= '0;
            imm_q     <= '0;
            dest_q    <= '0;
            src1_q    <= '0;
            cnt       <= '0;
            DATA1     <= '0;
            DATA2     <= '0;
            SELECT    <= '0;
            ZERO_FLAG <= 1'b0;
        end else begin
            if (state == IDLE && INSTR_VALID) begin
                op_q   <= INSTR[OP_HI:OP_LO];
                dest_q <= INSTR[DEST_HI:DEST_LO];
                src1_q <= INSTR[SRC1_HI:SRC1_LO];
                imm_q  <= INSTR[IMM_HI:IMM_LO];
            end
            // operands latch here so dest==src sees pre-write values
            if (state == DECODE && legal) begin
                DATA1  <= d1_nxt;
                DATA2  <= d2_nxt;
                SELECT <= sel_nxt;
                cnt    <= cnt_nxt;
            end
            if (state == EXEC) cnt <= cnt - 4'd1;
            if (state == WB && is_arith(op_q)) ZERO_FLAG <= ZERO;
        end
    end

    assign INSTR_READY = RESET && (state == IDLE);
    assign DONE        = (state == WB);
    assign ILLEGAL     = (state == DECODE) && !legal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU; vectors are table driven and
// a queue scoreboard pairs each issued instruction with its writeback check.
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] INSTR = '0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [7:0]  DATA1, DATA2;
    logic [2:0]  SELECT;
    logic [7:0]  RESULT;
    logic        ZERO;
    logic        DONE, ILLEGAL, ZERO_FLAG;
    logic [2:0]  DBG_ADDR = '0;
    logic [7:0]  DBG_DATA;
    logic [7:0]  sum;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  val;
        logic        zf;
        logic        illegal;
        int          lat;
        logic [2:0]  sel;
    } vec_t;

    vec_t tbl[17];
    vec_t exp_q[$];

    alu_issue_ctrl dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
        .RESULT(RESULT), .ZERO(ZERO), .DONE(DONE), .ILLEGAL(ILLEGAL),
        .ZERO_FLAG(ZERO_FLAG), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        sum = DATA1 + DATA2;
        case (SELECT)
            3'b001:  RESULT = sum;
            3'b010:  RESULT = DATA1 & DATA2;
            3'b011:  RESULT = DATA1 | DATA2;
            default: RESULT = DATA2;
        endcase
        ZERO = (sum == 8'd0);
    end

    function automatic vec_t mk(input logic [31:0] i, input logic [7:0] v, input logic z,
                                input logic il, input int l, input logic [2:0] s);
        vec_t r;
        r.instr = i; r.val = v; r.zf = z; r.illegal = il; r.lat = l; r.sel = s;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        bit ok = 0;
        exp_q.push_back(v);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (INSTR_READY) begin ok = 1; break; end
        end
        chk("ready_before_issue", 32'(ok), 1);
        INSTR = v.instr;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        INSTR_VALID = 1'b0;
        INSTR = '1;
    endtask

    task automatic retire();
        vec_t e;
        int k = 0;
        e = exp_q.pop_front();
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (DONE || ILLEGAL) begin k = i; break; end
        end
        chk("latency", 32'(k), 32'(e.lat));
        chk("illegal_pulse", 32'(ILLEGAL), 32'(e.illegal));
        if (!e.illegal) chk("select", 32'(SELECT), 32'(e.sel));
        @(posedge CLK);
        #1;
        DBG_ADDR = e.instr[18:16];
        #1;
        chk("reg_value", 32'(DBG_DATA), 32'(e.val));
        chk("zero_flag", 32'(ZERO_FLAG), 32'(e.zf));
        chk("pulse_one_cycle", 32'(DONE | ILLEGAL), 0);
        chk("ready_after", 32'(INSTR_READY), 1);
    endtask

    initial begin
        int acc, dn;
        bit ok;

        tbl[0]  = mk(32'h00010005, 8'h05, 0, 0, 3, 3'd0);
        tbl[1]  = mk(32'h000200FF, 8'hFF, 0, 0, 3, 3'd0);
        tbl[2]  = mk(32'h00030001, 8'h01, 0, 0, 3, 3'd0);
        tbl[3]  = mk(32'h02040203, 8'h00, 1, 0, 4, 3'd1);
        tbl[4]  = mk(32'h02040303, 8'h02, 0, 0, 4, 3'd1);
        tbl[5]  = mk(32'h000200F0, 8'hF0, 0, 0, 3, 3'd0);
        tbl[6]  = mk(32'h0003003C, 8'h3C, 0, 0, 3, 3'd0);
        tbl[7]  = mk(32'h02000000, 8'h00, 1, 0, 4, 3'd1);
        tbl[8]  = mk(32'h04050203, 8'h30, 1, 0, 3, 3'd2);
        tbl[9]  = mk(32'h05060203, 8'hFC, 1, 0, 3, 3'd3);
        tbl[10] = mk(32'h01070005, 8'h30, 1, 0, 3, 3'd0);
        tbl[11] = mk(32'h07070203, 8'h30, 1, 1, 1, 3'd0);
`ifdef ALU_ISSUE_SUB_EN
        tbl[12] = mk(32'h03070203, 8'hB4, 0, 0, 4, 3'd1);
        tbl[13] = mk(32'h03070303, 8'h00, 1, 0, 4, 3'd1);
`else
        tbl[12] = mk(32'h03070203, 8'h30, 1, 1, 1, 3'd0);
        tbl[13] = mk(32'h03070303, 8'h30, 1, 1, 1, 3'd0);
`endif
        tbl[14] = mk(32'h02030303, 8'h78, 0, 0, 4, 3'd1);
        tbl[15] = mk(32'h00F9FF5A, 8'h5A, 0, 0, 3, 3'd0);
        tbl[16] = mk(32'h01050005, 8'h30, 0, 0, 3, 3'd0);

        // reset state
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_ready_low", 32'(INSTR_READY), 0);
        chk("reset_done", 32'(DONE), 0);
        chk("reset_illegal", 32'(ILLEGAL), 0);
        chk("reset_zflag", 32'(ZERO_FLAG), 0);
        chk("reset_ops", {13'd0, SELECT, DATA1, DATA2}, 0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", 32'(INSTR_READY), 1);
        for (int r = 0; r < 8; r++) begin
            DBG_ADDR = 3'(r);
            #1 chk("reset_reg", 32'(DBG_DATA), 0);
        end

        foreach (tbl[i]) begin
            issue(tbl[i]);
            retire();
        end

        // back-pressure: VALID held high, one acceptance per IDLE visit
        acc = 0;
        dn = 0;
        @(negedge CLK);
        INSTR = 32'h00010011;
        INSTR_VALID = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge CLK);
            if (INSTR_READY) acc++;
            if (DONE) dn++;
        end
        INSTR_VALID = 1'b0;
        chk("bp_accepts", 32'(acc), 3);
        chk("bp_dones", 32'(dn), 3);
        @(posedge CLK);
        #1 DBG_ADDR = 3'd1;
        #1 chk("bp_reg", 32'(DBG_DATA), 32'h11);

        // reset while an add is in EXEC aborts writeback
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (INSTR_READY) begin ok = 1; break; end
        end
        chk("ready_before_abort", 32'(ok), 1);
        INSTR = 32'h02040203;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1 INSTR_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1 chk("ready_in_reset", 32'(INSTR_READY), 0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 0) chk("ready_post_abort", 32'(INSTR_READY), 1);
            if (DONE) dn++;
        end
        chk("abort_no_done", 32'(dn), 0);
        chk("abort_zflag", 32'(ZERO_FLAG), 0);
        for (int r = 0; r < 8; r++) begin
            DBG_ADDR = 3'(r);
            #1 chk("abort_reg", 32'(DBG_DATA), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
